// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter: two-state FSM with one idle bubble between grants.
// Define RR_ARB_TIMEOUT_EN to build a grant-hold counter that force-releases after TIMEOUT_CYCLES.
module rr_arbiter_8 #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {S_IDLE, S_GRANT} state_e;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] gnt_q, gnt_d;
  logic       valid_q, valid_d;
  logic [2:0] pick, cand;
  logic       found;
  logic       release_req;
  logic       force_rel;

`ifdef RR_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  // Circular search starting at ptr_q; the first set request wins.
  always_comb begin
    pick  = ptr_q;
    cand  = '0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cand = ptr_q + 3'(i);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  assign release_req = done || !req[idx_q];

`ifdef RR_ARB_TIMEOUT_EN
  // A normal release on the limit edge wins, so the forced path is masked by it.
  assign force_rel = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) && !release_req;
`else
  assign force_rel = 1'b0;
`endif

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path can infer a latch.
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
`ifdef RR_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (en && found) begin
          state_d = S_GRANT;
          idx_d   = pick;
          valid_d = 1'b1;
          gnt_d   = 8'b1 << pick;
`ifdef RR_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_GRANT: begin
        if (release_req || force_rel) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          gnt_d   = 8'b0;
          ptr_d   = idx_q + 3'd1;
`ifdef RR_ARB_TIMEOUT_EN
          timeout_d = force_rel;
`endif
        end else begin
`ifdef RR_ARB_TIMEOUT_EN
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= 3'd0;
      idx_q   <= 3'd0;
      gnt_q   <= 8'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed self-checking bench for rr_arbiter_8; the timeout test follows RR_ARB_TIMEOUT_EN.
module tb_rr_arbiter_8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int n_checks = 0;
  int n_pass   = 0;

  rr_arbiter_8 #(.TIMEOUT_CYCLES(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are then sampled and inputs driven 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 8'h00; done = 1'b0; en = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 8'hFF; en = 1'b1; done = 1'b0;
    tick(); tick();
    n_checks++; if (gnt !== 8'h00) $display("FAIL reset_gnt: got %h expected 00", gnt); else n_pass++;
    n_checks++; if (gnt_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", gnt_valid); else n_pass++;
    n_checks++; if (gnt_idx !== 3'd0) $display("FAIL reset_idx: got %0d expected 0", gnt_idx); else n_pass++;
    n_checks++; if (timeout !== 1'b0) $display("FAIL reset_timeout: got %b expected 0", timeout); else n_pass++;
    rst = 1'b0; req = 8'h00;
    tick();
  endtask

  task automatic test_single();
    req = 8'h08; en = 1'b1;
    tick();
    n_checks++; if (gnt !== 8'h08) $display("FAIL single_gnt: got %h expected 08", gnt); else n_pass++;
    n_checks++; if (gnt_idx !== 3'd3) $display("FAIL single_idx: got %0d expected 3", gnt_idx); else n_pass++;
    n_checks++; if (gnt_valid !== 1'b1) $display("FAIL single_valid: got %b expected 1", gnt_valid); else n_pass++;
    req = 8'h48; tick();
    n_checks++; if (gnt !== 8'h08) $display("FAIL single_hold: got %h expected 08", gnt); else n_pass++;
    done = 1'b1; tick(); done = 1'b0; req = 8'h00;
    n_checks++; if (gnt !== 8'h00) $display("FAIL single_release: got %h expected 00", gnt); else n_pass++;
    n_checks++; if (gnt_idx !== 3'd3) $display("FAIL single_idx_retain: got %0d expected 3", gnt_idx); else n_pass++;
    // Pointer now at 4: with requests 3 and 4 pending, 4 must win.
    req = 8'h18; tick();
    n_checks++; if (gnt !== 8'h10) $display("FAIL single_ptr4: got %h expected 10", gnt); else n_pass++;
    req = 8'h00; tick();
    n_checks++; if (gnt_valid !== 1'b0) $display("FAIL single_drop_req: got %b expected 0", gnt_valid); else n_pass++;
  endtask

  task automatic test_rotation();
    logic [7:0] exp_gnt;
    do_reset();
    req = 8'hFF; en = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      exp_gnt = 8'b1 << (k % 8);
      n_checks++;
      if (gnt !== exp_gnt || gnt_idx !== 3'(k % 8))
        $display("FAIL rotation_grant%0d: got gnt=%h idx=%0d expected gnt=%h idx=%0d", k, gnt, gnt_idx, exp_gnt, k % 8);
      else n_pass++;
      done = 1'b1; tick(); done = 1'b0;
      n_checks++;
      if (gnt !== 8'h00 || gnt_valid !== 1'b0)
        $display("FAIL rotation_bubble%0d: got gnt=%h valid=%b expected gnt=00 valid=0", k, gnt, gnt_valid);
      else n_pass++;
    end
    req = 8'h00;
  endtask

  task automatic test_enable_wrap();
    do_reset();
    en = 1'b0; req = 8'h81;
    tick(); tick();
    n_checks++; if (gnt !== 8'h00 || gnt_valid !== 1'b0) $display("FAIL en_off: got gnt=%h valid=%b expected 00/0", gnt, gnt_valid); else n_pass++;
    en = 1'b1; tick();
    n_checks++; if (gnt !== 8'h01) $display("FAIL en_on_first: got %h expected 01", gnt); else n_pass++;
    done = 1'b1; tick(); done = 1'b0; tick();
    n_checks++; if (gnt !== 8'h80) $display("FAIL wrap_to7: got %h expected 80", gnt); else n_pass++;
    done = 1'b1; tick(); done = 1'b0; tick();
    n_checks++; if (gnt !== 8'h01) $display("FAIL wrap_to0: got %h expected 01", gnt); else n_pass++;
    en = 1'b0; tick();
    n_checks++; if (gnt !== 8'h01) $display("FAIL en_ignored_in_grant: got %h expected 01", gnt); else n_pass++;
    req = 8'h00; en = 1'b1; tick();
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    en = 1'b1; req = 8'h20;
    tick();
    n_checks++; if (gnt_idx !== 3'd5 || gnt !== 8'h20) $display("FAIL midrst_grant: got gnt=%h idx=%0d expected 20/5", gnt, gnt_idx); else n_pass++;
    rst = 1'b1; tick(); rst = 1'b0;
    n_checks++; if (gnt !== 8'h00 || gnt_valid !== 1'b0 || gnt_idx !== 3'd0) $display("FAIL midrst_clear: got gnt=%h valid=%b idx=%0d expected 00/0/0", gnt, gnt_valid, gnt_idx); else n_pass++;
    req = 8'h21; tick();
    n_checks++; if (gnt !== 8'h01) $display("FAIL midrst_ptr0: got %h expected 01", gnt); else n_pass++;
    req = 8'h00; tick();
  endtask

  task automatic test_timeout();
    int bad;
    do_reset();
    en = 1'b1; req = 8'h04; done = 1'b0;
    tick();
`ifdef RR_ARB_TIMEOUT_EN
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (gnt !== 8'h04 || timeout !== 1'b0) bad++;
      tick();
    end
    n_checks++; if (bad != 0) $display("FAIL timeout_hold16: got %0d bad cycles expected 0", bad); else n_pass++;
    n_checks++; if (gnt !== 8'h00 || timeout !== 1'b1) $display("FAIL timeout_pulse: got gnt=%h timeout=%b expected 00/1", gnt, timeout); else n_pass++;
    tick();
    n_checks++; if (gnt !== 8'h04 || timeout !== 1'b0) $display("FAIL timeout_regrant: got gnt=%h timeout=%b expected 04/0", gnt, timeout); else n_pass++;
    for (int i = 0; i < 15; i++) tick();
    done = 1'b1; tick(); done = 1'b0;
    n_checks++; if (gnt !== 8'h00 || timeout !== 1'b0) $display("FAIL timeout_done_wins: got gnt=%h timeout=%b expected 00/0", gnt, timeout); else n_pass++;
`else
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (gnt !== 8'h04 || timeout !== 1'b0) bad++;
      tick();
    end
    n_checks++; if (bad != 0) $display("FAIL no_timeout_hold100: got %0d bad cycles expected 0", bad); else n_pass++;
`endif
    req = 8'h00; tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_enable_wrap();
    test_reset_mid_grant();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_8.md
RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum cycles one grant may be held (used only with RR_ARB_TIMEOUT_EN).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port en, input, 1, arbitration enable; when 0, no new grant is issued.
REQ-005 SHALL have port req, input, 8, request per requester; bit i belongs to requester i.
REQ-006 SHALL have port done, input, 1, the current grant holder releases the resource.
REQ-007 SHALL have port gnt, output, 8, registered one-hot grant (3:8 decode of gnt_idx, gated by gnt_valid).
REQ-008 SHALL have port gnt_idx, output, 3, binary index of the granted requester.
REQ-009 SHALL have port gnt_valid, output, 1, high while a grant is active.
REQ-010 SHALL have port timeout, output, 1, one-cycle pulse on a forced release.

Function
REQ-011 SHALL implement a two-state FSM: IDLE and GRANT.
REQ-012 SHALL hold a 3-bit priority pointer ptr; the highest-priority requester is ptr, then ptr+1 ... ptr+7, modulo 8.
REQ-013 IDLE: if en=1 and req!=0 at an edge, SHALL load gnt_idx with the first set req bit searching circularly from ptr, set gnt_valid=1 and enter GRANT; gnt is visible in the cycle after the edge.
REQ-014 IDLE: if en=0 or req=0, SHALL stay IDLE with gnt=0 and gnt_valid=0.
REQ-015 GRANT: SHALL hold gnt, gnt_idx and gnt_valid unchanged while req[gnt_idx]=1 and done=0; req changes on other bits and en are ignored.
REQ-016 GRANT: if done=1 or req[gnt_idx]=0 at an edge, SHALL clear gnt and gnt_valid, set ptr=gnt_idx+1 (7 wraps to 0) and enter IDLE.
REQ-017 SHALL insert at least one IDLE cycle between consecutive grants (one-cycle bubble).
REQ-018 gnt SHALL be 8'b0 whenever gnt_valid=0 and SHALL have exactly one bit set, equal to bit gnt_idx, whenever gnt_valid=1.
REQ-019 gnt_idx SHALL retain its last value in IDLE.
REQ-020 With all 8 requests held continuously and done pulsed once per grant, SHALL grant requesters 0,1,...,7,0 in order (starvation-free).
REQ-021 timeout SHALL be 0 except as defined in REQ-026.

Reset
REQ-022 With rst=1 at a rising edge, SHALL set state=IDLE, ptr=0, gnt=8'b0, gnt_idx=3'b0, gnt_valid=0, timeout=0, hold counter=0.
REQ-023 rst SHALL take priority over all other inputs, including an active grant; ptr does not advance on a reset release.
REQ-024 rst SHALL have no effect between clock edges.

Configuration
REQ-025 Macro RR_ARB_TIMEOUT_EN SHALL compile in a grant-hold counter that clears on grant entry and increments each GRANT cycle.
REQ-026 With RR_ARB_TIMEOUT_EN defined: when the counter reaches TIMEOUT_CYCLES-1 with no release, the next edge SHALL release as in REQ-016 and pulse timeout=1 for one cycle; a normal release on that same edge takes precedence (no pulse).
REQ-027 Without RR_ARB_TIMEOUT_EN: no counter is built, timeout is tied to 0, and grants are held indefinitely.

Verification
REQ-028 Reset: rst=1 for 2 cycles with req=8'hFF, en=1 -> gnt=8'h00, gnt_valid=0, gnt_idx=0, timeout=0.
REQ-029 Single requester: req=8'h08, en=1 -> next cycle gnt=8'h08, gnt_idx=3; done=1 for 1 cycle -> gnt=8'h00 next cycle, ptr=4.
REQ-030 Rotation: req=8'hFF held, done pulsed each grant -> gnt_idx sequence 0,1,2,3,4,5,6,7,0, with one gnt=8'h00 cycle between grants.
REQ-031 Enable and wrap: en=0, req=8'h81 -> no grant; en=1 -> gnt=8'h01; done -> next gnt=8'h80; done -> next gnt=8'h01 (7 wraps to 0).
REQ-032 Reset mid-grant: grant active on requester 5, rst=1 for one edge -> gnt=8'h00; then req=8'h21 -> gnt=8'h01 (ptr back to 0).
REQ-033 Timeout (macro defined, TIMEOUT_CYCLES=16): req=8'h04 held, done=0 -> gnt=8'h04 for exactly 16 cycles, then gnt=8'h00 with timeout=1 for 1 cycle; without macro, gnt stays 8'h04 for 100 cycles with timeout=0.
